// File: rtl/canvas_pkg.sv
// Shared canvas geometry, ink levels, pixel type, controller state encoding
// and a saturating ink accumulator.
package canvas_pkg;

    localparam int ORIGIN_X = 199;
    localparam int ORIGIN_Y = 43;
    localparam int CELL     = 14;
    localparam int GRID     = 28;

    localparam logic [15:0] INK_CENTER = 16'd512;
    localparam logic [15:0] INK_EDGE   = 16'd256;
    localparam logic [15:0] INK_CORNER = 16'd128;
    localparam logic [15:0] MAX_VAL    = 16'h07FF;

    typedef logic [15:0] pixel_t;

    typedef enum logic [2:0] {
        IDLE,
        LOCATE,
        PAINT,
        CLEAR,
        STREAM
    } ctrl_state_t;

    // 17-bit add so the carry is visible, then clamp to the display ceiling
    function automatic pixel_t sat_add(input pixel_t a, input pixel_t b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, MAX_VAL}) ? MAX_VAL : s[15:0];
    endfunction

endpackage

// File: rtl/cell_locator.sv
// Iterative divide-by-CELL for one axis: loads an offset on start, then removes
// one cell width per cycle until the remainder fits inside a single cell.
module cell_locator
    import canvas_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       start,
    input  logic [9:0] value,
    output logic       done,
    output logic [4:0] quotient
);

    logic [9:0] rem;
    logic       running;

    // Load on start, otherwise subtract one CELL per cycle while it still fits
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rem      <= '0;
            quotient <= '0;
            running  <= 1'b0;
        end else if (start) begin
            rem      <= value;
            quotient <= '0;
            running  <= 1'b1;
        end else if (running && rem >= 10'(CELL)) begin
            rem      <= rem - 10'(CELL);
            quotient <= quotient + 5'd1;
        end
    end

    // Quotient is final once the remainder is below one cell
    assign done = running && (rem < 10'(CELL));

endmodule

// File: rtl/canvas_controller.sv
// 28x28 digit canvas: paints 3x3 brush strokes at the cursor once per frame,
// clears on request, and streams the frozen canvas row-major over valid/ready.
module canvas_controller
    import canvas_pkg::*;
(
    input  logic                              Clk,
    input  logic                              Reset,
    input  logic [9:0]                        BallX,
    input  logic [9:0]                        BallY,
    input  logic                              frame_tick,
    input  logic                              paint,
    input  logic                              clear_req,
    input  logic                              infer_req,
    output pixel_t [GRID-1:0][GRID-1:0]       canvas,
    output logic                              pix_valid,
    output pixel_t                            pix_data,
    output logic                              pix_last,
    input  logic                              pix_ready,
    output logic                              busy
);

    ctrl_state_t state;
    logic        clr_pend, inf_pend;
    logic        in_x, in_y, paint_go;
    logic [9:0]  dx, dy;
    logic        x_done, y_done;
    logic [4:0]  cx, cy;
    logic [1:0]  ox, oy;      // brush offset + 1, so 0..2
    logic [4:0]  col;         // column being cleared
    logic [4:0]  sx, sy;      // stream position
    logic [4:0]  nx, ny;      // next stream position
    logic [5:0]  tx6, ty6;    // brush target, wraps past 63 when below zero
    logic        brush_in;
    pixel_t      ink;

    assign in_x = (BallX >= 10'(ORIGIN_X)) && (BallX < 10'(ORIGIN_X + GRID*CELL));
    assign in_y = (BallY >= 10'(ORIGIN_Y)) && (BallY < 10'(ORIGIN_Y + GRID*CELL));
    assign dx   = BallX - 10'(ORIGIN_X);
    assign dy   = BallY - 10'(ORIGIN_Y);

    // A stroke only starts from a quiet IDLE; pending clear/infer win
    assign paint_go = (state == IDLE) && !clr_pend && !inf_pend &&
                      frame_tick && paint && in_x && in_y;

    assign busy = (state != IDLE);

    cell_locator u_loc_x (
        .Clk      (Clk),
        .Reset    (Reset),
        .start    (paint_go),
        .value    (dx),
        .done     (x_done),
        .quotient (cx)
    );

    cell_locator u_loc_y (
        .Clk      (Clk),
        .Reset    (Reset),
        .start    (paint_go),
        .value    (dy),
        .done     (y_done),
        .quotient (cy)
    );

    // Brush target cell and ink weight for the current offset
    always_comb begin
        tx6      = 6'(cx) + 6'(ox) - 6'd1;
        ty6      = 6'(cy) + 6'(oy) - 6'd1;
        brush_in = (tx6 < 6'(GRID)) && (ty6 < 6'(GRID));
        if (ox == 2'd1 && oy == 2'd1)
            ink = INK_CENTER;
        else if ((ox == 2'd1) ^ (oy == 2'd1))
            ink = INK_EDGE;
        else
            ink = INK_CORNER;
    end

    // Row-major successor of the stream position
    always_comb begin
        nx = sx + 5'd1;
        ny = sy;
        if (sx == 5'(GRID-1)) begin
            nx = '0;
            ny = sy + 5'd1;
        end
    end

    // Canvas storage: written only while painting or clearing
    always_ff @(posedge Clk) begin
        if (Reset) begin
            canvas <= '0;
        end else if (state == PAINT && brush_in) begin
            canvas[tx6[4:0]][ty6[4:0]] <= sat_add(canvas[tx6[4:0]][ty6[4:0]], ink);
        end else if (state == CLEAR) begin
            canvas[col] <= '0;
        end
    end

    // Controller FSM with request latching and the stream output registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            clr_pend  <= 1'b0;
            inf_pend  <= 1'b0;
            ox        <= '0;
            oy        <= '0;
            col       <= '0;
            sx        <= '0;
            sy        <= '0;
            pix_valid <= 1'b0;
            pix_last  <= 1'b0;
            pix_data  <= '0;
        end else begin
            if (clear_req) clr_pend <= 1'b1;
            if (infer_req) inf_pend <= 1'b1;
            case (state)
                IDLE: begin
                    if (clr_pend) begin
                        clr_pend <= clear_req;   // a same-cycle request stays pending
                        col      <= '0;
                        state    <= CLEAR;
                    end else if (inf_pend) begin
                        inf_pend <= infer_req;
                        sx       <= '0;
                        sy       <= '0;
                        state    <= STREAM;
                    end else if (paint_go) begin
                        state <= LOCATE;
                    end
                end
                LOCATE: begin
                    if (x_done && y_done) begin
                        ox    <= '0;
                        oy    <= '0;
                        state <= PAINT;
                    end
                end
                PAINT: begin
                    if (ox == 2'd2) begin
                        ox <= '0;
                        if (oy == 2'd2) state <= IDLE;
                        else            oy    <= oy + 2'd1;
                    end else begin
                        ox <= ox + 2'd1;
                    end
                end
                CLEAR: begin
                    col <= col + 5'd1;
                    if (col == 5'(GRID-1)) state <= IDLE;
                end
                STREAM: begin
                    if (!pix_valid) begin
                        pix_valid <= 1'b1;
                        pix_data  <= canvas[sx][sy];
                        pix_last  <= 1'b0;
                    end else if (pix_ready) begin
                        if (pix_last) begin
                            pix_valid <= 1'b0;
                            pix_last  <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            sx       <= nx;
                            sy       <= ny;
                            pix_data <= canvas[nx][ny];
                            pix_last <= (nx == 5'(GRID-1)) && (ny == 5'(GRID-1));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_canvas_controller.sv
// Self-checking bench for canvas_controller: table-driven strokes, timing
// sequences for paint/clear/stream, and random strokes against a canvas model.
module tb_canvas_controller;

    logic                        Clk = 1'b0;
    logic                        Reset;
    logic [9:0]                  BallX, BallY;
    logic                        frame_tick, paint, clear_req, infer_req;
    logic [27:0][27:0][15:0]     canvas;
    logic                        pix_valid, pix_last, pix_ready, busy;
    logic [15:0]                 pix_data;

    int n_cmp = 0;
    int n_bad = 0;
    int model [28][28];

    typedef struct {
        int bx, by, n;
        int ccx, ccy, c_want;   // ccx < 0 marks a stroke outside the canvas
        int ex, ey, e_want;
        int kx, ky, k_want;
    } vec_t;

    vec_t vecs [10];

    canvas_controller dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .BallX      (BallX),
        .BallY      (BallY),
        .frame_tick (frame_tick),
        .paint      (paint),
        .clear_req  (clear_req),
        .infer_req  (infer_req),
        .canvas     (canvas),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .pix_last   (pix_last),
        .pix_ready  (pix_ready),
        .busy       (busy)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input int act, input int want);
        n_cmp++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, want);
        end
    endtask

    function automatic void model_clear();
        for (int x = 0; x < 28; x++)
            for (int y = 0; y < 28; y++)
                model[x][y] = 0;
    endfunction

    // Stroke from the rules: cell = offset/14, 3x3 brush, weights 512/256/128, cap 2047
    function automatic void model_stroke(input int bx, input int by);
        int cx, cy, w;
        if (bx < 199 || bx >= 199 + 392 || by < 43 || by >= 43 + 392) return;
        cx = (bx - 199) / 14;
        cy = (by - 43) / 14;
        for (int ddy = -1; ddy <= 1; ddy++)
            for (int ddx = -1; ddx <= 1; ddx++) begin
                if (cx + ddx < 0 || cx + ddx > 27 || cy + ddy < 0 || cy + ddy > 27) continue;
                w = (ddx == 0 && ddy == 0) ? 512 : ((ddx == 0 || ddy == 0) ? 256 : 128);
                model[cx+ddx][cy+ddy] = (model[cx+ddx][cy+ddy] + w > 2047) ? 2047
                                        : model[cx+ddx][cy+ddy] + w;
            end
    endfunction

    task automatic cmp_canvas(input string name);
        int diffs = 0, fx = 0, fy = 0;
        for (int x = 0; x < 28; x++)
            for (int y = 0; y < 28; y++)
                if (int'(canvas[x][y]) != model[x][y]) begin
                    if (diffs == 0) begin fx = x; fy = y; end
                    diffs++;
                end
        n_cmp++;
        if (diffs != 0) begin
            n_bad++;
            $display("FAIL %s: %0d cells differ, first [%0d][%0d] got %0d expected %0d",
                     name, diffs, fx, fy, canvas[fx][fy], model[fx][fy]);
        end
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            @(negedge Clk);
            k++;
        end
        if (busy) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_timeout: busy got 1 expected 0");
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        frame_tick = 0; paint = 0; clear_req = 0; infer_req = 0; pix_ready = 0;
        BallX = '0; BallY = '0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        model_clear();
    endtask

    task automatic stroke(input int bx, input int by, input bit pnt);
        wait_idle(100);
        BallX = 10'(bx); BallY = 10'(by); paint = pnt; frame_tick = 1'b1;
        @(negedge Clk);
        frame_tick = 1'b0;
        @(negedge Clk);
        wait_idle(100);
        paint = 1'b0;
        if (pnt) model_stroke(bx, by);
    endtask

    // Waits for CLEAR to start and counts how long busy stays high
    task automatic measure_clear(input string name);
        int w = 0, c = 0;
        while (!busy && w < 5) begin @(negedge Clk); w++; end
        while (busy && c < 100) begin @(negedge Clk); c++; end
        check(name, c, 28);
        model_clear();
    endtask

    task automatic do_clear();
        wait_idle(100);
        clear_req = 1'b1;
        @(negedge Clk);
        clear_req = 1'b0;
        measure_clear("clear_cycles");
    endtask

    // mode 0: ready toggles 1/0, mode 1: random ready. reset_at > 0 resets after that beat.
    task automatic stream(input int mode, input bit inject, input int reset_at);
        int idx = 0, cyc = 0, bad_data = 0, bad_last = 0, bad_stall = 0, want;
        bit st = 0, r;
        logic [15:0] sd;
        logic sl;
        wait_idle(100);
        infer_req = 1'b1;
        @(negedge Clk);
        infer_req = 1'b0;
        while (idx < 784 && cyc < 5000) begin
            @(negedge Clk);
            cyc++;
            if (inject) begin
                case (cyc)
                    50: begin BallX = 10'd272; BallY = 10'd142; paint = 1; frame_tick = 1; end
                    51: begin frame_tick = 0; paint = 0; end
                    120: clear_req = 1;
                    121: clear_req = 0;
                    default: ;
                endcase
            end
            if (st && (!pix_valid || pix_data !== sd || pix_last !== sl)) bad_stall++;
            r = (mode == 0) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            pix_ready = r;
            if (pix_valid) begin
                if (pix_last != (idx == 783)) bad_last++;
                if (r) begin
                    want = model[idx % 28][idx / 28];
                    if (int'(pix_data) != want) begin
                        if (bad_data == 0)
                            $display("FAIL beat_data: beat %0d got %0d expected %0d", idx, pix_data, want);
                        bad_data++;
                    end
                    idx++;
                    if (idx == reset_at) begin
                        Reset = 1'b1;
                        break;
                    end
                end
            end
            st = pix_valid && !r;
            sd = pix_data;
            sl = pix_last;
        end
        check("stream_data_errors", bad_data, 0);
        check("stream_last_errors", bad_last, 0);
        check("stream_stall_errors", bad_stall, 0);
        @(negedge Clk);
        pix_ready = 1'b0;
        if (reset_at > 0) begin
            check("reset_beats", idx, reset_at);
            Reset = 1'b0;
            model_clear();
            check("reset_mid_valid", int'(pix_valid), 0);
            check("reset_mid_busy", int'(busy), 0);
            cmp_canvas("reset_mid_canvas");
        end else begin
            check("stream_beats", idx, 784);
            check("post_stream_valid", int'(pix_valid), 0);
            check("post_stream_busy", int'(busy), 0);
        end
    endtask

    initial begin
        int c0, c22, cend, bcnt, sum;

        vecs[0] = '{272, 142, 1,  5,  7,  512,  4,  7,  256,  6,  8, 128};
        vecs[1] = '{272, 142, 5,  5,  7, 2047,  5,  8, 1280,  4,  6, 640};
        vecs[2] = '{199,  43, 1,  0,  0,  512,  0,  1,  256,  1,  1, 128};
        vecs[3] = '{212,  57, 2,  0,  1, 1024,  0,  0,  512,  1,  2, 256};
        vecs[4] = '{590, 434, 1, 27, 27,  512, 27, 26,  256, 26, 26, 128};
        vecs[5] = '{590,  43, 3, 27,  0, 1536, 26,  0,  768, 26,  1, 384};
        vecs[6] = '{198, 100, 1, -1,  0,    0,  0,  0,    0,  0,  0,   0};
        vecs[7] = '{591, 100, 1, -1,  0,    0,  0,  0,    0,  0,  0,   0};
        vecs[8] = '{300,  42, 1, -1,  0,    0,  0,  0,    0,  0,  0,   0};
        vecs[9] = '{300, 435, 1, -1,  0,    0,  0,  0,    0,  0,  0,   0};

        do_reset();
        check("reset_valid", int'(pix_valid), 0);
        check("reset_last", int'(pix_last), 0);
        check("reset_data", int'(pix_data), 0);
        check("reset_busy", int'(busy), 0);
        cmp_canvas("reset_canvas");

        // Table-driven strokes, each on a freshly cleared canvas
        for (int i = 0; i < 10; i++) begin
            if (i > 0) do_clear();
            repeat (vecs[i].n) stroke(vecs[i].bx, vecs[i].by, 1'b1);
            if (vecs[i].ccx >= 0) begin
                check($sformatf("vec%0d_center", i), int'(canvas[vecs[i].ccx][vecs[i].ccy]), vecs[i].c_want);
                check($sformatf("vec%0d_edge", i), int'(canvas[vecs[i].ex][vecs[i].ey]), vecs[i].e_want);
                check($sformatf("vec%0d_corner", i), int'(canvas[vecs[i].kx][vecs[i].ky]), vecs[i].k_want);
            end else begin
                sum = 0;
                for (int x = 0; x < 28; x++)
                    for (int y = 0; y < 28; y++)
                        sum += int'(canvas[x][y]);
                check($sformatf("vec%0d_outside_sum", i), sum, 0);
            end
            cmp_canvas($sformatf("vec%0d_canvas", i));
        end

        // PAINT length: first offset writes [0][0], last writes [2][2] as busy drops.
        // A second tick while busy must be ignored.
        do_clear();
        BallX = 10'd218; BallY = 10'd62; paint = 1'b1; frame_tick = 1'b1;
        @(negedge Clk);
        frame_tick = 1'b0;
        c0 = -1; c22 = -1; cend = -1; bcnt = 0;
        for (int k = 1; k <= 60 && cend < 0; k++) begin
            @(negedge Clk);
            if (k == 2) begin frame_tick = 1'b1; BallX = 10'd300; BallY = 10'd300; end
            if (k == 3) frame_tick = 1'b0;
            if (busy) bcnt++;
            if (c0 < 0 && canvas[0][0] != 16'd0) c0 = k;
            if (c22 < 0 && canvas[2][2] != 16'd0) c22 = k;
            if (cend < 0 && bcnt > 0 && !busy) cend = k;
        end
        paint = 1'b0;
        check("paint_cycles", cend - c0, 8);
        check("paint_last_write", c22, cend);
        check("busy_bound", int'(bcnt >= 10 && bcnt <= 37), 1);
        model_stroke(218, 62);
        cmp_canvas("paint_drop_canvas");

        // Random strokes, with occasional clears
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0) do_clear();
            stroke(int'($urandom_range(190, 600)), int'($urandom_range(35, 440)),
                   $urandom_range(0, 3) != 0);
            cmp_canvas($sformatf("rand%0d_canvas", i));
        end

        // Stream with toggling ready; paint and clear during STREAM
        stream(0, 1'b1, 0);
        cmp_canvas("stream_frozen_canvas");
        measure_clear("post_stream_clear_cycles");
        cmp_canvas("post_stream_clear_canvas");
        check("post_clear_busy", int'(busy), 0);

        // Reset mid-stream, then a fresh stream of zeros
        for (int i = 0; i < 6; i++)
            stroke(int'($urandom_range(199, 590)), int'($urandom_range(43, 434)), 1'b1);
        cmp_canvas("pre_reset_canvas");
        stream(1, 1'b0, 300);
        stream(1, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
